// File: rtl/onchip_mem_dma_master.sv
// onchip_mem_dma_master: word-wise COPY / FILL / CHECKSUM engine driving a
// latency-1, no-waitrequest Avalon-MM memory slave; every output is registered.
module onchip_mem_dma_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W-1:0]   length,
    input  logic [DATA_W-1:0]   fill_value,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [DATA_W-1:0]   checksum,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                m_clken
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FILL, SUM, DONE} state_t;
    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d, src_q, src_d, dst_q, dst_d, len_q, len_d, addr_q, addr_d;
    logic [DATA_W-1:0] fill_q, fill_d, sum_q, sum_d, wdata_q, wdata_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, cs_q, cs_d, we_q, we_d;
    logic [ADDR_W:0] nxt;
    logic last, bad, go;
    assign nxt  = {1'b0, i_q} + (ADDR_W+1)'(1);
    assign last = nxt >= {1'b0, len_q};
    // 17-bit sums so an end address of exactly DEPTH is still legal
    assign bad  = mode == 2'd3
               || (mode != 2'd1 && {1'b0, src_addr} + {1'b0, length} > LIM)
               || (mode != 2'd2 && {1'b0, dst_addr} + {1'b0, length} > LIM);
    assign go   = !(bad || length == '0);
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                src_d   = src_addr;
                dst_d   = dst_addr;
                len_d   = length;
                fill_d  = fill_value;
                i_d     = '0;
                sum_d   = '0;
                err_d   = bad;
                state_d = !go ? DONE : mode == 2'd0 ? RD : mode == 2'd1 ? FILL : SUM;
                addr_d  = mode == 2'd1 ? dst_addr : src_addr;
                wdata_d = fill_value;
                cs_d    = go;
                we_d    = go && mode == 2'd1;
                busy_d  = go;
                done_d  = !go;
            end
            RD:   state_d = CAP;
            CAP: begin
                state_d = WR;
                addr_d  = dst_q + i_q;
                wdata_d = m_readdata;
                sum_d   = sum_q + m_readdata;
                cs_d    = 1'b1;
                we_d    = 1'b1;
            end
            WR: begin
                i_d     = nxt[ADDR_W-1:0];
                state_d = last ? DONE : RD;
                addr_d  = src_q + nxt[ADDR_W-1:0];
                cs_d    = !last;
                busy_d  = !last;
                done_d  = last;
            end
            FILL: begin
                i_d     = nxt[ADDR_W-1:0];
                sum_d   = sum_q + fill_q;
                state_d = last ? DONE : FILL;
                addr_d  = dst_q + nxt[ADDR_W-1:0];
                cs_d    = !last;
                we_d    = !last;
                busy_d  = !last;
                done_d  = last;
            end
            // i_q is the index being addressed; data for index i_q-1 arrives now
            SUM: begin
                i_d     = nxt[ADDR_W-1:0];
                sum_d   = i_q != '0 ? sum_q + m_readdata : sum_q;
                state_d = i_q == len_q ? DONE : SUM;
                addr_d  = src_q + nxt[ADDR_W-1:0];
                cs_d    = !last;
                busy_d  = i_q != len_q;
                done_d  = i_q == len_q;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
        end
    end
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;
    assign checksum     = sum_q;
    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write      = we_q;
    assign m_writedata  = wdata_q;
    assign m_byteenable = '1;
    assign m_clken      = 1'b1;
endmodule

// File: doc/onchip_mem_dma_master.md
Name: onchip_mem_dma_master

Overview:
- Avalon-MM master engine that drives the on-chip memory's single-port slave interface (s1) from the other end.
- Performs word-wise block operations, started from a simple control interface owned by the game controller: COPY (src→dst), FILL (constant→dst), CHECKSUM (sum of src).
- Relieves the Nios/soft logic of bulk frame/board-state moves.
- All memory accesses are whole 32-bit words with fixed read latency 1 and no waitrequest.

Parameters:
- ADDR_W, 16, word-address width driven to memory.
- DATA_W, 32, data width.
- DEPTH, 50000, number of legal words; addresses at or above DEPTH are illegal.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  0=COPY, 1=FILL, 2=CHECKSUM, 3=reserved (treated as error)
- src_addr  in  16  first source word address
- dst_addr  in  16  first destination word address
- length  in  16  word count; 0 is legal no-op
- fill_value  in  32  FILL pattern
- busy  out  1  high while an operation runs
- done  out  1  one-cycle completion pulse
- error  out  1  status of last op, held until next accepted start
- checksum  out  32  sum of words of last op, held until next accepted start
- m_address  out  16  memory word address
- m_chipselect  out  1  access strobe
- m_write  out  1  write qualifier
- m_byteenable  out  4  always 4'hF
- m_writedata  out  32  write data
- m_readdata  in  32  read data, valid the cycle after a read address
- m_clken  out  1  constant 1, including during reset

Behaviour:
- Outputs: all registered.
  - Reset values: busy, done, error, m_chipselect, m_write = 0; m_address, m_writedata, checksum = 0.
  - Async reset mid-operation aborts immediately (chipselect low the same instant). No resume.
- Parameters are latched on acceptance: at the clock edge ending cycle 0 in which start=1 in IDLE, src, dst, length, mode and fill_value are latched, and checksum and the word index i are cleared.
- start while busy: ignored; inputs are not re-latched.
- Range check at accept, 17-bit arithmetic: error if src+length>DEPTH (COPY/CHECKSUM), dst+length>DEPTH (COPY/FILL), or mode=3.
  - On error, or when length=0: no memory access; busy stays 0; done=1 in cycle 1; error=1 or 0 respectively.
- States: IDLE, RD, CAP, WR, FILL, SUM, DONE.
- COPY: RD → CAP → WR per word, 3 cycles/word.
  - RD: chipselect=1, write=0, address=src+i.
  - CAP: chipselect=0; m_readdata registered into the buffer; checksum += data.
  - WR: chipselect=1, write=1, address=dst+i, writedata=buffer. Then i++; go to RD if i<length, else DONE.
  - busy is high in cycles 1..3*length. Last write is in cycle 3*length. done is in cycle 3*length+1.
- FILL: one write per cycle in cycles 1..length to dst+i, with writedata=fill_value and checksum += fill_value. done is in cycle length+1.
- CHECKSUM: pipelined.
  - Reads src+i in cycles 1..length, back-to-back.
  - m_readdata is accumulated in cycles 2..length+1.
  - chipselect=0 in cycle length+1.
  - done is in cycle length+2, with checksum final.
- Arithmetic: checksum is a 32-bit modulo-2^32 sum. Address increments never wrap, because the range check precedes them.
- Overlap: COPY is strictly ascending.
  - With dst in (src, src+length), the source is overwritten before it is read; the result is periodic replication with period dst-src. This is defined behaviour.
  - dst==src rewrites identical data.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start in the DONE cycle is ignored.
  - A start in the following cycle is accepted.
- m_chipselect is 0 in IDLE, CAP and DONE. m_write is 1 only in WR/FILL.

Test Plan:
- FILL dst=0x0100, len=4, fill=0xDEADBEEF -> 4 consecutive write cycles at 0x100..0x103; done in cycle 5; checksum=0x7AB6FBBC; error=0.
- Preload 0x10..0x12 = 1, 2, 0xFFFFFFFF; COPY src=0x10 dst=0x20 len=3 -> 0x20..0x22 match; done in cycle 10; checksum=0x00000002 (wrap).
- CHECKSUM src=0x10 len=3 on same data -> reads in cycles 1-3 with no writes; done in cycle 5; checksum=2.
- COPY src=0x10 dst=0x11 len=3 with 0x10..0x13 = A,B,C,D -> 0x11..0x13 = A,A,A; 0x10=A.
- Range/no-op cases:
  - FILL dst=49998 len=3 -> no chipselect; done in cycle 1 with error=1.
  - len=0 -> done in cycle 1, error=0.
  - mode=3 -> error=1.
- Assert reset in cycle 4 of a len=8 COPY -> chipselect, busy and done are 0 immediately; the memory holds only the words already written; a new start after reset runs normally.
